// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone generator.
//   - chromatic note frequencies C4..B4 in milli-Hz
//   - hp_calc(): rounded half-period in clock cycles for a given note
//   - tone_state_e: controller states
//   - NUM_NOTES: default table size
package tone_pkg;

  localparam int NUM_NOTES = 12;

  localparam logic [31:0] C4_MHZ  = 32'd261626;
  localparam logic [31:0] CS4_MHZ = 32'd277183;
  localparam logic [31:0] D4_MHZ  = 32'd293665;
  localparam logic [31:0] DS4_MHZ = 32'd311127;
  localparam logic [31:0] E4_MHZ  = 32'd329628;
  localparam logic [31:0] F4_MHZ  = 32'd349228;
  localparam logic [31:0] FS4_MHZ = 32'd369994;
  localparam logic [31:0] G4_MHZ  = 32'd391995;
  localparam logic [31:0] GS4_MHZ = 32'd415305;
  localparam logic [31:0] A4_MHZ  = 32'd440000;
  localparam logic [31:0] AS4_MHZ = 32'd466164;
  localparam logic [31:0] B4_MHZ  = 32'd493883;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } tone_state_e;

  function automatic logic [31:0] note_mhz(input int idx);
    case (idx)
      0:       return C4_MHZ;
      1:       return CS4_MHZ;
      2:       return D4_MHZ;
      3:       return DS4_MHZ;
      4:       return E4_MHZ;
      5:       return F4_MHZ;
      6:       return FS4_MHZ;
      7:       return G4_MHZ;
      8:       return GS4_MHZ;
      9:       return A4_MHZ;
      10:      return AS4_MHZ;
      11:      return B4_MHZ;
      default: return A4_MHZ;
    endcase
  endfunction

  // round(clk_hz / (2 * f)) with f in milli-Hz:
  // (clk_hz*1000 + f) / (2*f) adds half the divisor before truncating.
  function automatic logic [63:0] hp_calc(input logic [63:0] clk_hz, input int idx);
    logic [63:0] f_mhz;
    f_mhz = 64'(note_mhz(idx));
    return (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
  endfunction

endpackage

// File: rtl/tone_halfperiod_cnt.sv
// tone_halfperiod_cnt: loadable wrapping half-period counter.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   load_i      - capture hp_i and restart the count at 0 (wins over counting)
//   hp_i        - half-period length in cycles
//   run_i       - count enable
//   wrap_o      - high in the cycle the count sits at hp-1 while running
module tone_halfperiod_cnt #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] hp_i,
  input  logic             run_i,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;

  assign wrap_o = run_i && (cnt_q == hp_q - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    hp_d  = hp_q;
    if (load_i) begin
      hp_d  = hp_i;
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      hp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hp_q  <= hp_d;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator, one note from a chromatic table,
// selected through a valid/ready handshake. Note changes and stops take
// effect only on output toggles so freqOut never glitches.
// Optional feature macro: TONE_OCTAVE_EN adds the octave port (half-period
// right-shift, clamped to a minimum of 2 cycles).
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   enable       - 1 = run/accept notes, 0 = stop at the next falling toggle
//   note_sel     - requested note index, note_valid/note_ready handshake
//   octave       - half-period shift 0..7 (TONE_OCTAVE_EN only)
//   freqOut      - registered tone output
//   edge_tick    - pulse in the cycle freqOut changes
//   active       - in RUN or PEND
//
// state   | meaning
// IDLE    | output parked low, waiting for a note
// RUN     | tone running, no request waiting
// PEND    | tone running, new note waiting for the next toggle
module tone_gen #(
  parameter  int CLK_HZ    = 100_000_000,
  parameter  int CNT_W     = 26,
  parameter  int NUM_NOTES = tone_pkg::NUM_NOTES,
  localparam int NOTE_W    = $clog2(NUM_NOTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NOTE_W-1:0] note_sel,
  input  logic              note_valid,
  output logic              note_ready,
`ifdef TONE_OCTAVE_EN
  input  logic [2:0]        octave,
`endif
  output logic              freqOut,
  output logic              edge_tick,
  output logic              active
);

  import tone_pkg::*;

  logic [2:0] oct;
`ifdef TONE_OCTAVE_EN
  assign oct = octave;
`else
  assign oct = 3'd0;
`endif

  tone_state_e       state_q, state_d;
  logic              freq_q, freq_d;
  logic              tick_q, tick_d;
  logic [NOTE_W-1:0] pend_q, pend_d;
  logic [NOTE_W-1:0] load_idx;
  logic              load, wrap, run, accept, in_range;
  logic [CNT_W-1:0]  hp_tab [NUM_NOTES];
  logic [CNT_W-1:0]  hp_shift, hp_eff;

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_hp
    assign hp_tab[g] = CNT_W'(hp_calc(64'(CLK_HZ), g));
  end

  assign note_ready = reset && enable && (state_q != ST_PEND);
  assign accept     = note_valid && note_ready;
  // One extra bit so a power-of-two NUM_NOTES still compares correctly.
  assign in_range   = {1'b0, note_sel} < (NOTE_W+1)'(NUM_NOTES);
  assign run        = (state_q != ST_IDLE);

  // Octave is only consumed here, so it is effectively sampled on load.
  assign hp_shift = hp_tab[load_idx] >> oct;
  assign hp_eff   = (hp_shift < CNT_W'(2)) ? CNT_W'(2) : hp_shift;

  tone_halfperiod_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .hp_i   (hp_eff),
    .run_i  (run),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;
    load     = 1'b0;
    load_idx = note_sel;
    case (state_q)
      ST_IDLE: begin
        freq_d = 1'b0;
        if (accept && in_range) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          if (!enable) begin
            // Stop: a high output falls now; a low output just stays low.
            state_d = ST_IDLE;
            freq_d  = 1'b0;
            tick_d  = freq_q;
          end else begin
            freq_d = ~freq_q;
            tick_d = 1'b1;
          end
        end
        // A request landing on a wrap cycle waits for the following toggle.
        if (accept && in_range) begin
          pend_d  = note_sel;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          if (!enable) begin
            state_d = ST_IDLE;
            freq_d  = 1'b0;
            tick_d  = freq_q;
          end else begin
            freq_d   = ~freq_q;
            tick_d   = 1'b1;
            load     = 1'b1;
            load_idx = pend_q;
            state_d  = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      freq_q  <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
    end
  end

  assign freqOut   = freq_q;
  assign edge_tick = tick_q;
  assign active    = (state_q != ST_IDLE);

endmodule

// File: doc/tone_gen.md
# tone_gen

Parametrised square-wave tone generator for the synthesizer audio path: one note per instance from a 12-entry chromatic table, selectable at runtime via a valid/ready handshake. Note changes and stops happen only on output edges, so the output never glitches. Optional octave shift. Sits between the keypad/sequencer front end and the output mixer/pin driver.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; sets the half-period table.
- `CNT_W`, 26: half-period counter width; must hold the largest half-period count.
- `NUM_NOTES`, 12: number of table entries (C4..B4); `NOTE_W = $clog2(NUM_NOTES)`.
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `enable`  in  1: 1 = run/accept notes; 0 = request glitch-free stop.
- `note_sel`  in  NOTE_W: requested note index (0 = C4 … 9 = A4 … 11 = B4).
- `note_valid`  in  1: `note_sel` valid.
- `note_ready`  out  1: request accepted when `note_valid && note_ready`.
- `octave`  in  3: right-shift of half-period, 0..7. Present only with `TONE_OCTAVE_EN`.
- `freqOut`  out  1: square-wave tone output, registered.
- `edge_tick`  out  1: one-cycle pulse in the cycle `freqOut` toggles.
- `active`  out  1: 1 while in RUN or PEND.

## Operation
- HP(n) = round(CLK_HZ / (2·f_n)), with f_n from the package table. A4 at 100 MHz gives 113636. Effective HP = max(HP(n) >> octave, 2).
- Reset values: `freqOut`=0, `edge_tick`=0, `active`=0, `note_ready`=0 during reset and 1 after. State = IDLE, counter = 0, current note = 0, no pending request.
- `note_ready` = `enable` && no pending request.
- IDLE: `freqOut` held at 0. An accepted note loads its HP, clears the counter and moves to RUN.
- RUN: counter runs 0..HP−1 and wraps. In the cycle it wraps, `freqOut` toggles and `edge_tick`=1.
- RUN, accepted request: stored as pending, `note_ready` drops, move to PEND.
- PEND: at the next toggle, load the pending HP (counter restarts at 0), clear pending, return to RUN.
- A request accepted in the same cycle as a toggle applies at the following toggle, not the current one.
- Out-of-range `note_sel` (≥ NUM_NOTES): handshake completes, request discarded, no state change.
- `enable` low in RUN/PEND: keep counting. At the next toggle that takes `freqOut` to 0 (or immediately on a wrap if already 0), go to IDLE and drop any pending request. `enable` returning high before then cancels the stop.
- Octave is sampled only when an HP is loaded.
- Reset mid-operation: all state returns to reset values at the next edge.

## Timing
- Request accepted at edge E0 from IDLE: `freqOut` rises at edge E0+HP. Full period = 2·HP cycles.
- Note change latency: applied at the first toggle strictly after acceptance; the new half-period starts there.
- `edge_tick` coincides with the `freqOut` change cycle; no extra latency.
- Counter arithmetic is unsigned CNT_W; the compare is against HP−1.

## Configuration
- `TONE_OCTAVE_EN` defined: `octave` port exists and the shift/clamp applies.
- `TONE_OCTAVE_EN` undefined: no `octave` port, shift is 0, table HP used directly.

## Structure
- Package `tone_pkg` holds: note frequency constants (milli-Hz, C4..B4), the HP rounding function, the state enum (IDLE/RUN/PEND), and `NUM_NOTES`.
- Sub-module `tone_halfperiod_cnt`: loadable wrapping counter with a wrap pulse output.

## Test plan
- CLK_HZ=8800, reset released, note 9 accepted → `freqOut` rises 10 cycles later; period 20 cycles; `edge_tick` once every 10 cycles.
- Running A4, note 0 (C4, HP=17) accepted mid half-period → current 10-cycle half completes, following halves are 17; `note_ready` low until the switch.
- Request accepted in a toggle cycle → next half still 10 cycles, then the new HP.
- `note_sel`=13 → accepted, output unchanged; `enable` dropped while `freqOut`=1 → falls at the scheduled toggle, IDLE, `active`=0.
- `TONE_OCTAVE_EN`, octave=1, A4 → HP 5; octave=7 → clamped HP 2.
- Reset asserted mid-high → next edge `freqOut`=0, `active`=0; re-run after release matches the first scenario.
